prefetch_lane_fifo: RTL

Parametrised prefetch queue between the prefetch/TLB fetch path and the decoder. Stores wide fetch entries of LANES lanes, each lane being a byte-length plus 64-bit code word, and hands them to the decoder one lane at a time. Skips unused lanes and injects GP/PF fault markers. Successor of the fixed two-lane prefetch queue: adds configurable lane count and depth, simultaneous pop-and-write when full, an almost-full threshold, and an optional overflow monitor.

---
 rtl/prefetch_pkg.sv | 38 +++
 rtl/prefetch_lane_fifo_if.sv | 32 +++
 rtl/prefetch_lane_ring.sv | 57 +++++
 rtl/prefetch_lane_fifo.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared prefetch definitions: lane geometry, fault marker codes and lane
// index/range helpers used by the lane FIFO and its ring buffer.
// The fault codes carry the project values of PREFETCH_GP_FAULT and
// PREFETCH_PF_FAULT.
package prefetch_pkg;

  localparam int LANE_W = 68;
  localparam int LEN_W  = 4;
  localparam int DATA_W = 64;

  localparam logic [LEN_W-1:0] FAULT_GP = 4'd15;
  localparam logic [LEN_W-1:0] FAULT_PF = 4'd14;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_GP,
    SRC_PF,
    SRC_WRITE
  } src_e;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } lane_t;

  function automatic int laneIdxW(int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic int laneLo(int k);
    return k * LANE_W;
  endfunction

  function automatic int laneLenLo(int k);
    return k * LANE_W + DATA_W;
  endfunction

endpackage

// File: rtl/prefetch_lane_fifo_if.sv
// Bus between the fetch path / decoder and the prefetch lane FIFO.
// Names are seen from the FIFO: i_* flow into it, o_* flow out of it.
interface prefetch_lane_fifo_if #(
  parameter int LANES      = 2,
  parameter int DEPTH_LOG2 = 4
);
  import prefetch_pkg::*;

  logic                      i_pr_reset;
  logic                      i_limit_do;
  logic                      i_pf_do;
  logic                      i_write_do;
  logic [LANES*LANE_W-1:0]   i_write_data;
  logic [DEPTH_LOG2:0]       o_used;
  logic                      o_full;
  logic                      o_almost_full;
  logic                      i_accept_do;
  logic [LANE_W-1:0]         o_accept_data;
  logic                      o_accept_empty;
  logic                      o_overflow;

  modport master (
    output i_pr_reset, i_limit_do, i_pf_do, i_write_do, i_write_data, i_accept_do,
    input  o_used, o_full, o_almost_full, o_accept_data, o_accept_empty, o_overflow
  );

  modport slave (
    input  i_pr_reset, i_limit_do, i_pf_do, i_write_do, i_write_data, i_accept_do,
    output o_used, o_full, o_almost_full, o_accept_data, o_accept_empty, o_overflow
  );

endinterface

// File: rtl/prefetch_lane_ring.sv
// Show-ahead register-array ring buffer holding whole prefetch entries.
// A push is taken when there is room or when the same cycle pops, so a full
// ring can stream at one entry per cycle. Clear empties it synchronously.
module prefetch_lane_ring
  import prefetch_pkg::*;
#(
  parameter int WIDTH      = 2 * LANE_W,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [WIDTH-1:0]      i_data,
  output logic [WIDTH-1:0]      o_q,
  output logic [DEPTH_LOG2:0]   o_used,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rd;
  logic [DEPTH_LOG2-1:0] r_wr;
  logic [DEPTH_LOG2:0]   r_used;
  logic                  w_pop;
  logic                  w_push;

  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_used  = r_used;
  assign o_full  = (r_used == (DEPTH_LOG2+1)'(DEPTH));
  assign o_empty = (r_used == '0);
  assign o_q     = r_mem[r_rd];

  // Pointers and occupancy; a clear drops everything regardless of push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_used <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_used <= r_used + 1'b1;
      else if (w_pop && !w_push) r_used <= r_used - 1'b1;
    end
  end

  // Entry storage; when full the write slot is the head being popped.
  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/prefetch_lane_fifo.sv
// Prefetch queue between the fetch/TLB path and the decoder. Entries of
// LANES lanes are stored whole and handed out one valid lane at a time;
// GP/PF fault markers are injected as single-lane entries.
// Optional: define PREFETCH_LANE_FIFO_OVF_EN to build the sticky overflow
// monitor; without it o_overflow is tied low.
module prefetch_lane_fifo
  import prefetch_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_LEVEL   = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  prefetch_lane_fifo_if.slave   bus
);

  localparam int LP_W    = laneIdxW(LANES);
  localparam int ENTRY_W = LANES * LANE_W;

  logic [LP_W-1:0]     r_lp;
  src_e                w_src;
  logic [ENTRY_W-1:0]  w_entry;
  logic [ENTRY_W-1:0]  w_q;
  logic                w_push;
  logic                w_accept;
  logic                w_advance;
  logic                w_popHead;
  logic                w_nextValid;
  logic [LANES:0]      w_laneValid;
  logic [DEPTH_LOG2:0] w_used;
  logic                w_full;
  logic                w_empty;
  lane_t               w_headLane;

  // Pick the enqueue source: GP fault beats PF fault beats plain data.
  always_comb begin
    w_src = SRC_NONE;
    if (bus.i_limit_do)      w_src = SRC_GP;
    else if (bus.i_pf_do)    w_src = SRC_PF;
    else if (bus.i_write_do) w_src = SRC_WRITE;
  end

  // Build the entry to store; fault markers carry only a lane-0 code.
  always_comb begin
    w_entry = '0;
    case (w_src)
      SRC_GP:    w_entry[LANE_W-1:0] = {FAULT_GP, {DATA_W{1'b0}}};
      SRC_PF:    w_entry[LANE_W-1:0] = {FAULT_PF, {DATA_W{1'b0}}};
      SRC_WRITE: w_entry = bus.i_write_data;
      default:   w_entry = '0;
    endcase
  end

  assign w_push = (w_src != SRC_NONE);

  prefetch_lane_ring #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (bus.i_pr_reset),
    .i_push  (w_push),
    .i_pop   (w_popHead),
    .i_data  (w_entry),
    .o_q     (w_q),
    .o_used  (w_used),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Lane validity is a prefix chain: a zero length ends the entry.
  always_comb begin : laneChain
    logic runValid;
    runValid       = 1'b1;
    w_laneValid    = '0;
    w_laneValid[0] = 1'b1;
    for (int k = 1; k < LANES; k++) begin
      runValid       = runValid & (w_q[laneLenLo(k) +: LEN_W] != '0);
      w_laneValid[k] = runValid;
    end
  end

  // Select the lane under lp and see whether another valid lane follows it.
  always_comb begin
    w_headLane  = '0;
    w_nextValid = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (r_lp == LP_W'(k)) begin
        w_headLane  = w_q[laneLo(k) +: LANE_W];
        w_nextValid = w_laneValid[k+1];
      end
    end
  end

  assign w_accept  = bus.i_accept_do & ~w_empty;
  assign w_advance = w_accept & w_nextValid;
  assign w_popHead = w_accept & ~w_nextValid;

  // Lane pointer: step within the head entry, rewind when it is retired or flushed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lp <= '0;
    end else if (bus.i_pr_reset || w_popHead) begin
      r_lp <= '0;
    end else if (w_advance) begin
      r_lp <= r_lp + LP_W'(1);
    end
  end

  assign bus.o_used         = w_used;
  assign bus.o_full         = w_full;
  assign bus.o_almost_full  = (int'(w_used) >= AF_LEVEL);
  assign bus.o_accept_empty = w_empty;
  assign bus.o_accept_data  = w_empty ? '0 : w_headLane;

`ifdef PREFETCH_LANE_FIFO_OVF_EN
  logic w_drop;
  logic r_overflow;

  assign w_drop = w_push & w_full & ~w_popHead & ~bus.i_pr_reset;

  // Sticky record of any write lost to a full queue; only rst_n clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

`ifndef SYNTHESIS
  // Announce each dropped write during simulation.
  always_ff @(posedge clk) begin
    if (rst_n && w_drop) $display("prefetch_lane_fifo: write dropped, queue full (t=%0t)", $time);
  end
`endif

  assign bus.o_overflow = r_overflow;
`else
  assign bus.o_overflow = 1'b0;
`endif

endmodule
